// File: rtl/bwt_pkg.sv
// rtl/bwt_pkg.sv - shared types and constants for the BWT job sequencer
package bwt_pkg;
    typedef logic [7:0] byte_t;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        DRAIN,
        PAD,
        START,
        WAIT,
        UNLOAD
    } seq_state_e;

    localparam byte_t NO_PRIMARY     = 8'hFF;
    localparam int    STRING_LEN_DEF = 32;
endpackage

// File: rtl/bwt_job_sequencer_if.sv
// rtl/bwt_job_sequencer_if.sv - byte-in / row-out stream bundle of the job sequencer
interface bwt_job_sequencer_if;
    import bwt_pkg::*;

    logic  s_valid;
    logic  s_ready;
    byte_t s_data;
    logic  s_last;

    logic  m_valid;
    logic  m_ready;
    byte_t m_bwt;
    byte_t m_sa;
    logic  m_last;

    modport slave (
        input  s_valid, s_data, s_last,
        output s_ready,
        output m_valid, m_bwt, m_sa, m_last,
        input  m_ready
    );

    modport master (
        output s_valid, s_data, s_last,
        input  s_ready,
        input  m_valid, m_bwt, m_sa, m_last,
        output m_ready
    );
endinterface

// File: rtl/bwt_result_buffer.sv
// rtl/bwt_result_buffer.sv - captured BWT/SA rows, row read counter, primary-index search
module bwt_result_buffer
    import bwt_pkg::*;
#(
    parameter int STRING_LEN = STRING_LEN_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   capture,
    input  logic                   advance,
    input  byte_t [STRING_LEN-1:0] eng_bwt,
    input  byte_t [STRING_LEN-1:0] eng_sa,
    output byte_t                  row_bwt,
    output byte_t                  row_sa,
    output logic                   row_last,
    output byte_t                  primary_idx
);
    localparam int CW = $clog2(STRING_LEN + 1);
    localparam int IW = $clog2(STRING_LEN);

    byte_t [STRING_LEN-1:0] out_bwt;
    byte_t [STRING_LEN-1:0] out_sa;
    logic  [CW-1:0]         rd_cnt;
    byte_t                  prim_search;

    // Scan downwards so the lowest matching row is the one that sticks.
    always_comb begin
        prim_search = NO_PRIMARY;
        for (int r = STRING_LEN - 1; r >= 0; r--) begin
            if (eng_sa[r] == 8'h00) prim_search = byte_t'(r);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_bwt     <= '0;
            out_sa      <= '0;
            rd_cnt      <= '0;
            primary_idx <= '0;
        end else if (capture) begin
            out_bwt     <= eng_bwt;
            out_sa      <= eng_sa;
            primary_idx <= prim_search;
            rd_cnt      <= '0;
        end else if (advance) begin
            rd_cnt <= row_last ? '0 : rd_cnt + CW'(1);
        end
    end

    assign row_last = (rd_cnt == CW'(STRING_LEN - 1));
    assign row_bwt  = out_bwt[rd_cnt[IW-1:0]];
    assign row_sa   = out_sa[rd_cnt[IW-1:0]];
endmodule

// File: rtl/bwt_job_sequencer.sv
// rtl/bwt_job_sequencer.sv - frame assembly, engine handshake and row streaming; watchdog under BWT_WATCHDOG_EN
module bwt_job_sequencer
    import bwt_pkg::*;
#(
    parameter int    STRING_LEN     = STRING_LEN_DEF,
    parameter byte_t PAD_BYTE       = 8'h00,
    parameter int    TIMEOUT_CYCLES = 65535
) (
    input  logic                   clk,
    input  logic                   rst,
    bwt_job_sequencer_if.slave     io,
    output byte_t                  primary_idx,
    output logic                   frame_err,
    output logic                   timeout_err,
    output logic                   busy,
    output logic                   eng_start,
    output byte_t [STRING_LEN-1:0] eng_string,
    input  logic                   eng_done,
    input  byte_t [STRING_LEN-1:0] eng_bwt,
    input  byte_t [STRING_LEN-1:0] eng_sa,
    output logic                   eng_abort
);
    localparam int CW = $clog2(STRING_LEN + 1);
    localparam int IW = $clog2(STRING_LEN);

    seq_state_e    state, state_next;
    logic [CW-1:0] wr_cnt;
    logic          wait_first;
    logic          accept, at_end, capture, expire, row_last;

    assign accept  = io.s_valid && io.s_ready;
    assign at_end  = (wr_cnt == CW'(STRING_LEN - 1));
    // A done level seen in the first WAIT cycle may belong to the previous job.
    assign capture = (state == WAIT) && eng_done && !wait_first;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:   if (accept) state_next = io.s_last ? PAD : LOAD;
            LOAD: begin
                if (accept) begin
                    if (at_end)         state_next = io.s_last ? START : DRAIN;
                    else if (io.s_last) state_next = PAD;
                end
            end
            DRAIN:  if (accept && io.s_last) state_next = START;
            PAD:    if (at_end) state_next = START;
            START:  state_next = WAIT;
            WAIT: begin
                if (capture)     state_next = UNLOAD;
                else if (expire) state_next = IDLE;
            end
            UNLOAD: if (io.m_ready && row_last) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        io.s_ready = state inside {IDLE, LOAD, DRAIN};
        io.m_valid = (state == UNLOAD);
        io.m_last  = (state == UNLOAD) && row_last;
        eng_start  = (state == START);
        busy       = (state != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            eng_string <= {STRING_LEN{PAD_BYTE}};
            wr_cnt     <= '0;
            frame_err  <= 1'b0;
            wait_first <= 1'b0;
        end else begin
            frame_err  <= (state == DRAIN) && accept && io.s_last;
            wait_first <= (state == START);
            case (state)
                IDLE: begin
                    if (accept) begin
                        eng_string[0] <= io.s_data;
                        wr_cnt        <= CW'(1);
                    end
                end
                LOAD: begin
                    if (accept) begin
                        eng_string[wr_cnt[IW-1:0]] <= io.s_data;
                        wr_cnt                     <= wr_cnt + CW'(1);
                    end
                end
                PAD: begin
                    eng_string[wr_cnt[IW-1:0]] <= PAD_BYTE;
                    wr_cnt                     <= wr_cnt + CW'(1);
                end
                START:   wr_cnt <= '0;
                default: ;
            endcase
        end
    end

`ifdef BWT_WATCHDOG_EN
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
    logic [WW-1:0] wd_cnt;

    always_ff @(posedge clk) begin
        if (rst || state != WAIT) wd_cnt <= '0;
        else                      wd_cnt <= wd_cnt + WW'(1);
    end

    // A done arriving on the expiry cycle wins over the timeout.
    assign expire = (state == WAIT) && !capture && (wd_cnt == WW'(TIMEOUT_CYCLES - 1));
`else
    // The timeout limit only matters when the watchdog is compiled in.
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES != 0);
    assign expire         = 1'b0;
`endif

    assign timeout_err = expire;
    assign eng_abort   = expire;

    bwt_result_buffer #(
        .STRING_LEN (STRING_LEN)
    ) u_result_buffer (
        .clk         (clk),
        .rst         (rst),
        .capture     (capture),
        .advance     (io.m_valid && io.m_ready),
        .eng_bwt     (eng_bwt),
        .eng_sa      (eng_sa),
        .row_bwt     (io.m_bwt),
        .row_sa      (io.m_sa),
        .row_last    (row_last),
        .primary_idx (primary_idx)
    );
endmodule

// File: tb/tb_bwt_job_sequencer.sv
// tb/tb_bwt_job_sequencer.sv - randomized scoreboard bench with a suffix-sorting engine model
module tb_bwt_job_sequencer;
    import bwt_pkg::*;

    localparam int N = 4;
    typedef logic [N-1:0][7:0] vec_t;
    typedef struct { byte_t bwt; byte_t sa; logic last; byte_t prim; } row_s;
    typedef struct { vec_t str; int mode; logic stale; } job_s;

    logic  clk = 1'b0;
    logic  rst = 1'b1;
    byte_t primary_idx;
    logic  frame_err, timeout_err, busy, eng_start, eng_abort;
    vec_t  eng_string;
    logic  eng_done = 1'b0;
    vec_t  eng_bwt  = '0;
    vec_t  eng_sa   = '0;

    always #5 clk = ~clk;

    bwt_job_sequencer_if io();

    bwt_job_sequencer #(
        .STRING_LEN     (N),
        .PAD_BYTE       (8'h00),
        .TIMEOUT_CYCLES (10)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .io          (io),
        .primary_idx (primary_idx),
        .frame_err   (frame_err),
        .timeout_err (timeout_err),
        .busy        (busy),
        .eng_start   (eng_start),
        .eng_string  (eng_string),
        .eng_done    (eng_done),
        .eng_bwt     (eng_bwt),
        .eng_sa      (eng_sa),
        .eng_abort   (eng_abort)
    );

    int    n_checks = 0, n_pass = 0;
    int    exp_ferr = 0, exp_starts = 0, exp_tmo = 0;
    int    seen_ferr = 0, seen_starts = 0, seen_tmo = 0;
    row_s  sb_q[$];
    job_s  job_q[$];
    byte_t frame_buf[8];

    task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Shorter suffix sorts first when it is a prefix of the longer one.
    function automatic bit suffix_less(input vec_t s, input int a, input int b);
        int i, j;
        i = a;
        j = b;
        while (i < N && j < N) begin
            if (s[i] != s[j]) return s[i] < s[j];
            i++;
            j++;
        end
        return i == N;
    endfunction

    function automatic void engine_model(input vec_t s, input int mode, output vec_t bwt, output vec_t sa);
        int idx[N];
        int t;
        for (int i = 0; i < N; i++) idx[i] = i;
        for (int p = 0; p < N; p++)
            for (int q = 0; q < N - 1 - p; q++)
                if (suffix_less(s, idx[q+1], idx[q])) begin
                    t = idx[q]; idx[q] = idx[q+1]; idx[q+1] = t;
                end
        for (int r = 0; r < N; r++) begin
            case (mode)
                0: begin sa[r] = 8'(idx[r]); bwt[r] = s[(idx[r] + N - 1) % N]; end
                1: begin sa[r] = 8'(s[r] % 8'd3); bwt[r] = s[r] ^ 8'hA5; end
                default: begin sa[r] = s[r] | 8'h01; bwt[r] = ~s[r]; end
            endcase
        end
    endfunction

    function automatic byte_t lowest_zero(input vec_t sa);
        for (int r = 0; r < N; r++) if (sa[r] == 8'h00) return 8'(r);
        return 8'hFF;
    endfunction

    task automatic send_frame(input int len);
        int  t;
        bit  ok;
        for (int i = 0; i < len; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                io.s_valid = 1'b0;
                @(posedge clk); #1;
            end
            io.s_valid = 1'b1;
            io.s_data  = frame_buf[i];
            io.s_last  = (i == len - 1);
            t = 0;
            do begin
                @(negedge clk);
                ok = io.s_ready;
                @(posedge clk); #1;
                t++;
            end while (!ok && t < 500);
            if (!ok) check(1'b0, "s_ready_wait", 0, 1);
        end
        io.s_valid = 1'b0;
        io.s_last  = 1'b0;
    endtask

    task automatic issue_job(input int len, input int mode, input bit stale);
        job_s  j;
        vec_t  bwt, sa;
        byte_t prim;
        row_s  r;
        for (int k = 0; k < N; k++) j.str[k] = (k < len) ? frame_buf[k] : 8'h00;
        j.mode  = mode;
        j.stale = stale;
        job_q.push_back(j);
        exp_starts++;
        if (len > N) exp_ferr++;
        if (mode != 3) begin
            engine_model(j.str, mode, bwt, sa);
            prim = lowest_zero(sa);
            for (int k = 0; k < N; k++) begin
                r.bwt = bwt[k]; r.sa = sa[k]; r.last = (k == N - 1); r.prim = prim;
                sb_q.push_back(r);
            end
        end
        send_frame(len);
    endtask

    task automatic wait_drain();
        int t = 0;
        while ((sb_q.size() != 0 || busy) && t < 2000) begin
            @(negedge clk);
            t++;
        end
        check(sb_q.size() == 0 && !busy, "drain", sb_q.size(), 0);
        @(posedge clk); #1;
    endtask

    // Engine: answers from the DUT's eng_string, checks it against the issued frame.
    initial begin : engine
        job_s c;
        vec_t bwt, sa;
        forever begin
            @(negedge clk);
            if (!rst && eng_start) begin
                if (job_q.size() == 0) begin
                    check(1'b0, "unexpected_start", 1, 0);
                end else begin
                    c = job_q.pop_front();
                    check(eng_string == c.str, "eng_string", eng_string, c.str);
                    engine_model(eng_string, c.mode, bwt, sa);
                    if (c.mode == 3) begin
                    end else if (c.stale) begin
                        eng_bwt = ~bwt; eng_sa = ~sa; eng_done = 1'b1;
                        @(negedge clk);
                        @(negedge clk);
                        eng_bwt = bwt; eng_sa = sa;
                        @(negedge clk);
                        eng_done = 1'b0;
                    end else begin
                        repeat ($urandom_range(2, 5)) @(negedge clk);
                        eng_bwt = bwt; eng_sa = sa; eng_done = 1'b1;
                        @(negedge clk);
                        eng_done = 1'b0;
                    end
                end
            end
        end
    end

    initial begin : ready_driver
        logic pat[4];
        int   cyc = 0;
        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
        io.m_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            io.m_ready = (cyc < 200) ? pat[cyc % 4] : ($urandom_range(0, 9) < 7);
            cyc++;
        end
    end

    initial begin : monitor
        row_s e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (frame_err) seen_ferr++;
                if (eng_start) seen_starts++;
                if (timeout_err || eng_abort) seen_tmo++;
                if (io.m_valid) begin
                    check(!io.s_ready, "no_overlap", io.s_ready, 0);
                    if (sb_q.size() == 0) begin
                        check(1'b0, "unexpected_row", {io.m_bwt, io.m_sa}, 0);
                    end else begin
                        e = sb_q[0];
                        check({io.m_bwt, io.m_sa, io.m_last, primary_idx} == {e.bwt, e.sa, e.last, e.prim},
                              "row", {io.m_bwt, io.m_sa, io.m_last, primary_idx}, {e.bwt, e.sa, e.last, e.prim});
                        if (io.m_ready) void'(sb_q.pop_front());
                    end
                end
            end
        end
    end

    initial begin : guard
        #400000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    initial begin : stimulus
        int t;
        io.s_valid = 1'b0;
        io.s_data  = '0;
        io.s_last  = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check(io.s_ready == 1'b1, "rst_s_ready", io.s_ready, 1);
        check(io.m_valid == 1'b0, "rst_m_valid", io.m_valid, 0);
        check(io.m_last == 1'b0, "rst_m_last", io.m_last, 0);
        check(busy == 1'b0, "rst_busy", busy, 0);
        check(eng_start == 1'b0, "rst_eng_start", eng_start, 0);
        check(frame_err == 1'b0, "rst_frame_err", frame_err, 0);
        check(primary_idx == 8'h00, "rst_primary_idx", primary_idx, 0);
        check(eng_string == '0, "rst_eng_string", eng_string, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        frame_buf[0] = 8'h61; frame_buf[1] = 8'h62; frame_buf[2] = 8'h63; frame_buf[3] = 8'h24;
        issue_job(4, 0, 1'b0);
        frame_buf[0] = 8'h41; frame_buf[1] = 8'h42;
        issue_job(2, 0, 1'b0);
        for (int i = 0; i < 6; i++) frame_buf[i] = 8'(8'h11 + i);
        issue_job(6, 1, 1'b0);
        for (int i = 0; i < 4; i++) frame_buf[i] = 8'($urandom_range(0, 255));
        issue_job(4, 0, 1'b1);

        for (int j = 0; j < 40; j++) begin
            int len;
            len = $urandom_range(1, 7);
            for (int i = 0; i < len; i++)
                frame_buf[i] = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
            issue_job(len, $urandom_range(0, 2), ($urandom_range(0, 3) == 0));
        end
        wait_drain();

        // Reset while rows are being streamed: the job is dropped.
        for (int i = 0; i < 4; i++) frame_buf[i] = 8'($urandom_range(1, 255));
        issue_job(4, 0, 1'b0);
        t = 0;
        do begin @(negedge clk); t++; end while (!io.m_valid && t < 100);
        check(io.m_valid == 1'b1, "unload_reached", io.m_valid, 1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        sb_q.delete();
        @(negedge clk);
        check(io.m_valid == 1'b0, "rst_unload_m_valid", io.m_valid, 0);
        check(busy == 1'b0, "rst_unload_busy", busy, 0);
        check(io.s_ready == 1'b1, "rst_unload_s_ready", io.s_ready, 1);
        check(eng_string == '0, "rst_unload_eng_string", eng_string, 0);
        check(primary_idx == 8'h00, "rst_unload_primary_idx", primary_idx, 0);
        @(posedge clk); #1;

`ifdef BWT_WATCHDOG_EN
        for (int i = 0; i < 4; i++) frame_buf[i] = 8'($urandom_range(0, 255));
        issue_job(4, 3, 1'b0);
        exp_tmo = 1;
        t = 0;
        do begin @(negedge clk); t++; end while (!eng_start && t < 50);
        check(eng_start == 1'b1, "wd_start", eng_start, 1);
        repeat (9) @(negedge clk);
        check(timeout_err == 1'b0, "wd_early", timeout_err, 0);
        @(negedge clk);
        check(timeout_err && eng_abort, "wd_expire", {timeout_err, eng_abort}, 2'b11);
        @(negedge clk);
        check(busy == 1'b0, "wd_idle", busy, 0);
        @(posedge clk); #1;
`endif

        for (int i = 0; i < 3; i++) frame_buf[i] = 8'($urandom_range(0, 255));
        issue_job(3, 0, 1'b0);
        wait_drain();

        check(seen_ferr == exp_ferr, "frame_err_count", seen_ferr, exp_ferr);
        check(seen_starts == exp_starts, "eng_start_count", seen_starts, exp_starts);
        check(seen_tmo == exp_tmo, "timeout_count", seen_tmo, exp_tmo);
        check(job_q.size() == 0, "engine_jobs_left", job_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
